// File: rtl/tilelink_ad_slave_q.sv
// TileLink A/D dummy slave with a DEPTH-entry request queue, multi-beat Put bursts and
// nondeterministic stalls/data. Define TL_ERROR_INJECT_EN to drive d_error from rand_error.
module tilelink_ad_slave_q #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SOURCE_W = 1,
  parameter int SIZE_W   = 4,
  parameter int DEPTH    = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       a_ready,
  input  logic                       a_valid,
  input  logic [2:0]                 a_opcode,
  input  logic [2:0]                 a_param,
  input  logic [SIZE_W-1:0]          a_size,
  input  logic [SOURCE_W-1:0]        a_source,
  input  logic [ADDR_W-1:0]          a_address,
  input  logic [DATA_W/8-1:0]        a_mask,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       d_ready,
  output logic                       d_valid,
  output logic [2:0]                 d_opcode,
  output logic [1:0]                 d_param,
  output logic [SIZE_W-1:0]          d_size,
  output logic [SOURCE_W-1:0]        d_source,
  output logic                       d_sink,
  output logic [DATA_W-1:0]          d_data,
  output logic                       d_error,
  input  logic                       stall_a,
  input  logic                       stall_d,
  input  logic [DATA_W-1:0]          rand_data,
  input  logic                       rand_error,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LG     = $clog2(BYTES);
  localparam int BEAT_W = 1 << SIZE_W;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH) + 1;
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_ARITH    = 3'd2;
  localparam logic [2:0] OP_LOGIC    = 3'd3;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_HINT     = 3'd5;

  typedef enum logic {A_IDLE, A_BURST} a_state_t;
  typedef enum logic {D_IDLE, D_RESP}  d_state_t;

  // Shift amount is formed in SIZE_W+1 bits so sizes below one bus word clamp to 1 beat.
  function automatic logic [BEAT_W-1:0] beats_of(input logic [SIZE_W-1:0] sz);
    logic [SIZE_W:0] sh;
    sh = {1'b0, sz} - (SIZE_W+1)'(LG);
    if ({1'b0, sz} <= (SIZE_W+1)'(LG)) return BEAT_W'(1);
    return BEAT_W'(1) << sh[SIZE_W-1:0];
  endfunction

  function automatic logic is_data_op(input logic [2:0] op);
    return (op == OP_ARITH) || (op == OP_LOGIC) || (op == OP_GET);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Request queue
  logic [2:0]          r_q_op   [DEPTH];
  logic [SIZE_W-1:0]   r_q_size [DEPTH];
  logic [SOURCE_W-1:0] r_q_src  [DEPTH];
  logic [PTR_W-1:0]    r_wptr, r_rptr;
  logic [OCC_W-1:0]    r_count;

  a_state_t            r_a_state, w_a_state_nxt;
  logic [2:0]          r_a_op;
  logic [SIZE_W-1:0]   r_a_size;
  logic [SOURCE_W-1:0] r_a_src;
  logic [BEAT_W-1:0]   r_a_cnt;

  d_state_t            r_d_state, w_d_state_nxt;
  logic [BEAT_W-1:0]   r_d_cnt, w_d_cnt_nxt;

  logic                w_in_burst, w_a_last, w_need_slot, w_a_fire, w_a_start;
  logic                w_enq, w_deq, w_d_fire, w_d_last, w_err_load;
  logic [2:0]          w_enq_op;
  logic [SIZE_W-1:0]   w_enq_size;
  logic [SOURCE_W-1:0] w_enq_src;
  logic [2:0]          w_h_op;
  logic [SIZE_W-1:0]   w_h_size;
  logic [SOURCE_W-1:0] w_h_src;
  logic [BEAT_W-1:0]   w_h_beats;

  assign w_in_burst  = ((a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART)) &&
                       (beats_of(a_size) != BEAT_W'(1));
  assign w_a_last    = (r_a_cnt + BEAT_W'(1)) == beats_of(r_a_size);
  // Only the beat that completes a request consumes a queue slot.
  assign w_need_slot = (r_a_state == A_BURST) ? w_a_last : !w_in_burst;
  assign a_ready     = !reset && !stall_a && (!w_need_slot || (r_count != FULL) || w_deq);
  assign w_a_fire    = a_valid && a_ready;

  assign w_h_op    = r_q_op[r_rptr];
  assign w_h_size  = r_q_size[r_rptr];
  assign w_h_src   = r_q_src[r_rptr];
  assign w_h_beats = is_data_op(w_h_op) ? beats_of(w_h_size) : BEAT_W'(1);
  assign d_valid   = !reset && (r_d_state == D_RESP) && !stall_d;
  assign w_d_fire  = d_valid && d_ready;
  assign w_d_last  = (r_d_cnt + BEAT_W'(1)) == w_h_beats;
  assign w_deq     = w_d_fire && w_d_last;

  always_ff @(posedge clock) begin
    if (reset) r_a_state <= A_IDLE;
    else       r_a_state <= w_a_state_nxt;
  end

  always_comb begin
    w_a_state_nxt = r_a_state;
    w_enq         = 1'b0;
    w_a_start     = 1'b0;
    w_enq_op      = a_opcode;
    w_enq_size    = a_size;
    w_enq_src     = a_source;
    case (r_a_state)
      A_IDLE: begin
        if (w_a_fire) begin
          if (w_in_burst) begin
            w_a_state_nxt = A_BURST;
            w_a_start     = 1'b1;
          end else begin
            w_enq = 1'b1;
          end
        end
      end
      A_BURST: begin
        w_enq_op   = r_a_op;
        w_enq_size = r_a_size;
        w_enq_src  = r_a_src;
        if (w_a_fire && w_a_last) begin
          w_enq         = 1'b1;
          w_a_state_nxt = A_IDLE;
        end
      end
      default: w_a_state_nxt = A_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_op   <= '0;
      r_a_size <= '0;
      r_a_src  <= '0;
      r_a_cnt  <= '0;
    end else if (w_a_start) begin
      r_a_op   <= a_opcode;
      r_a_size <= a_size;
      r_a_src  <= a_source;
      r_a_cnt  <= BEAT_W'(1);
    end else if ((r_a_state == A_BURST) && w_a_fire) begin
      r_a_cnt  <= r_a_cnt + BEAT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_q_op[r_wptr]   <= w_enq_op;
        r_q_size[r_wptr] <= w_enq_size;
        r_q_src[r_wptr]  <= w_enq_src;
        r_wptr           <= ptr_inc(r_wptr);
      end
      if (w_deq) r_rptr <= ptr_inc(r_rptr);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_d_state <= D_IDLE;
      r_d_cnt   <= '0;
    end else begin
      r_d_state <= w_d_state_nxt;
      r_d_cnt   <= w_d_cnt_nxt;
    end
  end

  // An incoming enqueue counts as non-empty so the first beat follows the A handshake directly.
  always_comb begin
    w_d_state_nxt = r_d_state;
    w_d_cnt_nxt   = r_d_cnt;
    w_err_load    = 1'b0;
    case (r_d_state)
      D_IDLE: begin
        if ((r_count != '0) || w_enq) begin
          w_d_state_nxt = D_RESP;
          w_d_cnt_nxt   = '0;
          w_err_load    = 1'b1;
        end
      end
      D_RESP: begin
        if (w_d_fire) begin
          if (w_d_last) begin
            w_d_cnt_nxt = '0;
            if ((r_count > OCC_W'(1)) || w_enq) begin
              w_d_state_nxt = D_RESP;
              w_err_load    = 1'b1;
            end else begin
              w_d_state_nxt = D_IDLE;
            end
          end else begin
            w_d_cnt_nxt = r_d_cnt + BEAT_W'(1);
          end
        end
      end
      default: w_d_state_nxt = D_IDLE;
    endcase
  end

`ifdef TL_ERROR_INJECT_EN
  logic r_err;
  always_ff @(posedge clock) begin
    if (reset)           r_err <= 1'b0;
    else if (w_err_load) r_err <= rand_error;
  end
  logic w_unused;
  assign w_unused = ^{a_param, a_address, a_mask, a_data};
`else
  logic w_unused;
  assign w_unused = ^{a_param, a_address, a_mask, a_data, rand_error, w_err_load};
`endif

  always_comb begin
    d_opcode = 3'd0;
    d_error  = 1'b0;
    d_data   = '0;
    if (!reset && (r_d_state == D_RESP)) begin
      case (w_h_op)
        OP_PUT_FULL, OP_PUT_PART: d_opcode = 3'd0;
        OP_ARITH, OP_LOGIC, OP_GET: begin
          d_opcode = 3'd1;
          d_data   = rand_data;
        end
        OP_HINT: d_opcode = 3'd2;
        default: begin
          d_opcode = 3'd0;
          d_error  = 1'b1;
        end
      endcase
`ifdef TL_ERROR_INJECT_EN
      if (w_h_op <= OP_HINT) d_error = r_err;
`endif
    end
  end

  assign d_param   = 2'd0;
  assign d_sink    = 1'b0;
  assign d_size    = w_h_size;
  assign d_source  = w_h_src;
  assign occupancy = reset ? '0 : r_count;

endmodule

// File: tb/tb_tilelink_ad_slave_q.sv
// Bench for tilelink_ad_slave_q: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-level transaction model.
module tb_tilelink_ad_slave_q;
  localparam int DATA_W = 32, ADDR_W = 32, SOURCE_W = 1, SIZE_W = 4, DEPTH = 2;
  localparam int BYTES = DATA_W / 8;
  localparam int RW = 3 + SIZE_W + SOURCE_W;

  logic clock, reset;
  logic a_ready, a_valid;
  logic [2:0] a_opcode, a_param;
  logic [SIZE_W-1:0] a_size;
  logic [SOURCE_W-1:0] a_source;
  logic [ADDR_W-1:0] a_address;
  logic [DATA_W/8-1:0] a_mask;
  logic [DATA_W-1:0] a_data;
  logic d_ready, d_valid;
  logic [2:0] d_opcode;
  logic [1:0] d_param;
  logic [SIZE_W-1:0] d_size;
  logic [SOURCE_W-1:0] d_source;
  logic d_sink;
  logic [DATA_W-1:0] d_data;
  logic d_error;
  logic stall_a, stall_d;
  logic [DATA_W-1:0] rand_data;
  logic rand_error;
  logic [$clog2(DEPTH):0] occupancy;

  tilelink_ad_slave_q #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W),
                        .SIZE_W(SIZE_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .a_ready(a_ready), .a_valid(a_valid),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .d_ready(d_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
    .stall_a(stall_a), .stall_d(stall_d), .rand_data(rand_data), .rand_error(rand_error),
    .occupancy(occupancy)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: request queue of {opcode, size, source} plus burst/beat progress
  logic [RW-1:0] exp_q[$];
  int m_dbeat = 0;
  bit m_burst = 0;
  int m_bgot = 0, m_btotal = 0;
  logic [RW-1:0] m_breq;

  function automatic int beats_f(input int size);
    int b;
    b = (1 << size) / BYTES;
    return (b < 1) ? 1 : b;
  endfunction

  function automatic bit data_op(input int op);
    return (op == 2) || (op == 3) || (op == 4);
  endfunction

  function automatic int exp_dop(input int op);
    if (data_op(op)) return 1;
    if (op == 5) return 2;
    return 0;
  endfunction

  always @(negedge clock) begin : compare
    int n_q, hop, hsz, hsrc, hb;
    bit edv, ear, deq, need, is_burst_start;
    logic [RW-1:0] h;
    if (reset) begin
      chk("rst_occupancy", occupancy, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_d_opcode", d_opcode, 0);
      chk("rst_d_error", d_error, 0);
      chk("rst_d_data", d_data, 0);
      exp_q.delete();
      m_dbeat = 0;
      m_burst = 0;
    end else begin
      n_q = exp_q.size();
      edv = !stall_d && (n_q > 0);
      deq = 0;
      hop = 0; hsz = 0; hsrc = 0; hb = 1;
      if (n_q > 0) begin
        h    = exp_q[0];
        hop  = int'(h[RW-1 -: 3]);
        hsz  = int'(h[SOURCE_W +: SIZE_W]);
        hsrc = int'(h[SOURCE_W-1:0]);
        hb   = data_op(hop) ? beats_f(hsz) : 1;
        deq  = edv && d_ready && (m_dbeat + 1 == hb);
      end
      is_burst_start = (a_opcode <= 3'd1) && (beats_f(int'(a_size)) > 1);
      need = m_burst ? (m_bgot + 1 == m_btotal) : !is_burst_start;
      ear  = !stall_a && (!need || (n_q < DEPTH) || deq);
      chk("occupancy", occupancy, n_q);
      chk("d_valid", d_valid, edv);
      chk("a_ready", a_ready, ear);
      if (edv && d_valid) begin
        chk("d_opcode", d_opcode, exp_dop(hop));
        chk("d_size", d_size, hsz);
        chk("d_source", d_source, hsrc);
        chk("d_param", d_param, 0);
        chk("d_sink", d_sink, 0);
`ifndef TL_ERROR_INJECT_EN
        chk("d_error", d_error, (hop >= 6) ? 1 : 0);
`endif
        if (data_op(hop)) chk("d_data", d_data, rand_data);
      end
      if (edv && d_ready) begin
        if (deq) begin
          void'(exp_q.pop_front());
          m_dbeat = 0;
        end else begin
          m_dbeat++;
        end
      end
      if (a_valid && ear) begin
        if (m_burst) begin
          m_bgot++;
          if (m_bgot == m_btotal) begin
            exp_q.push_back(m_breq);
            m_burst = 0;
          end
        end else if (is_burst_start) begin
          m_burst  = 1;
          m_bgot   = 1;
          m_btotal = beats_f(int'(a_size));
          m_breq   = {a_opcode, a_size, a_source};
        end else begin
          exp_q.push_back({a_opcode, a_size, a_source});
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
    rand_data  = $urandom;
    rand_error = 1'($urandom_range(0, 1));
    a_data     = $urandom;
    a_address  = $urandom;
  endtask

  task automatic peek();
    @(negedge clock);
    #1;
  endtask

  task automatic send(input int op, input int size, input int src);
    a_valid  = 1'b1;
    a_opcode = 3'(op);
    a_size   = SIZE_W'(size);
    a_source = SOURCE_W'(src);
  endtask

  task automatic idle(input int n);
    a_valid = 1'b0; stall_a = 1'b0; stall_d = 1'b0; d_ready = 1'b1;
    repeat (n) tick();
  endtask

  initial begin : main
    int hs, bad;
    reset = 1'b1; a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_source = '0; a_address = '0; a_mask = '1; a_data = '0; d_ready = 1'b1;
    stall_a = 1'b0; stall_d = 1'b0; rand_data = '0; rand_error = 1'b0;
    tick(); tick();
    peek();
    chk("lit_reset_a_ready", a_ready, 0);
    chk("lit_reset_d_valid", d_valid, 0);
    chk("lit_reset_occupancy", occupancy, 0);
    tick();
    reset = 1'b0;
    idle(2);

    // 4-beat Get, no stalls
    send(4, 4, 1);
    peek();
    chk("lit_get4_a_ready", a_ready, 1);
    chk("lit_get4_d_valid0", d_valid, 0);
    tick();
    a_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      peek();
      chk("lit_get4_d_valid", d_valid, 1);
      chk("lit_get4_d_opcode", d_opcode, 1);
      chk("lit_get4_d_size", d_size, 4);
      chk("lit_get4_d_source", d_source, 1);
`ifndef TL_ERROR_INJECT_EN
      chk("lit_get4_d_error", d_error, 0);
`endif
      tick();
    end
    peek();
    chk("lit_get4_done", d_valid, 0);
    idle(2);

    // 2-beat PutFullData then 1-beat Get
    send(0, 3, 0);
    peek();
    chk("lit_put_occ0", occupancy, 0);
    tick();
    send(0, 3, 0);
    peek();
    chk("lit_put_no_resp_yet", d_valid, 0);
    tick();
    send(4, 2, 0);
    peek();
    chk("lit_put_ack_valid", d_valid, 1);
    chk("lit_put_ack_opcode", d_opcode, 0);
    chk("lit_put_occ1", occupancy, 1);
    tick();
    a_valid = 1'b0;
    peek();
    chk("lit_put_get_opcode", d_opcode, 1);
    chk("lit_put_get_occ", occupancy, 1);
    tick();
    peek();
    chk("lit_put_drained", occupancy, 0);
    idle(2);

    // Queue full with d_ready low
    d_ready = 1'b0;
    send(4, 2, 0);
    tick();
    send(4, 2, 1);
    peek();
    chk("lit_full_occ1", occupancy, 1);
    tick();
    send(4, 2, 0);
    peek();
    chk("lit_full_a_ready", a_ready, 0);
    chk("lit_full_occ2", occupancy, 2);
    tick();
    d_ready = 1'b1;
    peek();
    chk("lit_full_accept_on_pop", a_ready, 1);
    chk("lit_full_head_src", d_source, 0);
    tick();
    a_valid = 1'b0;
    peek();
    chk("lit_full_occ_after", occupancy, 2);
    chk("lit_full_second_src", d_source, 1);
    idle(4);

    // stall_d toggling during a 4-beat Get
    send(4, 4, 0);
    tick();
    a_valid = 1'b0;
    hs = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      stall_d = (i % 2 == 0);
      peek();
      if (d_valid && d_ready) hs++;
      if (stall_d && d_valid) bad++;
      tick();
    end
    chk("lit_stall_handshakes", hs, 4);
    chk("lit_stall_valid_low", bad, 0);
    idle(2);

    // Intent then opcode 7
    send(5, 2, 0);
    tick();
    send(7, 2, 1);
    peek();
    chk("lit_hint_opcode", d_opcode, 2);
`ifndef TL_ERROR_INJECT_EN
    chk("lit_hint_error", d_error, 0);
`endif
    tick();
    a_valid = 1'b0;
    peek();
    chk("lit_op7_opcode", d_opcode, 0);
    chk("lit_op7_error", d_error, 1);
    idle(3);

    // Reset during the 2nd beat of a 4-beat Get
    send(4, 4, 0);
    tick();
    a_valid = 1'b0;
    peek();
    chk("lit_rst_beat1", d_valid, 1);
    tick();
    reset = 1'b1;
    tick();
    peek();
    chk("lit_rst_d_valid", d_valid, 0);
    chk("lit_rst_occ", occupancy, 0);
    chk("lit_rst_a_ready", a_ready, 0);
    chk("lit_rst_d_data", d_data, 0);
    tick();
    reset = 1'b0;
    peek();
    chk("lit_post_rst_idle", d_valid, 0);
    tick();
    send(4, 2, 1);
    peek();
    chk("lit_post_rst_accept", a_ready, 1);
    tick();
    a_valid = 1'b0;
    peek();
    chk("lit_post_rst_resp", d_valid, 1);
    chk("lit_post_rst_src", d_source, 1);
    idle(3);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      a_valid  = 1'($urandom_range(0, 1));
      a_opcode = 3'($urandom_range(0, 7));
      a_size   = SIZE_W'($urandom_range(0, 5));
      a_source = SOURCE_W'($urandom_range(0, 1));
      a_param  = 3'($urandom_range(0, 7));
      stall_a  = ($urandom_range(0, 3) == 0);
      stall_d  = ($urandom_range(0, 3) == 0);
      d_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset = 1'b0;
    idle(40);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
